// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   NOP_INST         : instruction shown to decode when nothing is available
//   DEFAULT_RESET_PC : default program counter after reset
//   fetch_entry_t    : one fetched {pc, inst} pair held in the fetch queue
//   align_word()     : clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package ifu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Value presented on the decode side when the queue is empty.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, inst: NOP_INST};

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ifu_fetch_if
// Bundles the fetch stage's bus signals: IROM address/data, redirect request
// from branch resolution, and the valid/ready handoff to decode.
//   master : the fetch stage (drives irom_addr and the id_* outputs)
//   slave  : the environment (IROM, branch unit, decode)
// ----------------------------------------------------------------------------
interface ifu_fetch_if #(
  parameter int IROM_AW = 14
);
  logic [IROM_AW-1:0] irom_addr;
  logic [31:0]        irom_data;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [31:0]        id_inst;
  logic [31:0]        id_pc;

  modport master (
    output irom_addr, id_valid, id_inst, id_pc,
    input  irom_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  irom_addr, id_valid, id_inst, id_pc,
    output irom_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifu_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Two-entry synchronous FIFO of fetch_entry_t between fetch and decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (accepted when not full, or full with i_pop)
//   i_pop      : discard the head entry (ignored when empty)
//   i_flush    : drop all entries; overrides push/pop
//   i_data     : entry to write
//   o_count    : number of valid entries, 0..2
//   o_head     : oldest entry, or EMPTY_ENTRY (NOP, pc 0) when empty
// ----------------------------------------------------------------------------
module fetch_fifo
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop_ok;
  logic         w_push_ok;

  // Qualify push/pop; a full queue may still push when the head leaves.
  always_comb begin
    w_pop_ok  = i_pop && (r_count != 2'd0);
    w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ~r_wr_ptr;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= EMPTY_ENTRY;
      r_mem[1] <= EMPTY_ENTRY;
    end else if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Head view: stored registers only, NOP/0 when nothing is queued.
  always_comb begin
    if (r_count == 2'd0) begin
      o_head = EMPTY_ENTRY;
    end else begin
      o_head = r_mem[r_rd_ptr];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch stage. Owns the PC, addresses the combinational IROM and
// queues each fetched {pc, inst} in a 2-entry FIFO that feeds decode.
// Parameters:
//   RESET_PC : PC after reset (word aligned)
//   IROM_AW  : IROM word-address width
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   fetch_bus  : ifu_fetch_if.master (irom_addr/irom_data, redirect_valid/
//                redirect_pc, id_valid/id_ready/id_inst/id_pc)
// Build option:
//   FETCH_BYPASS_EN : when defined, an empty queue forwards the IROM word
//                     straight to decode in the same cycle.
// ----------------------------------------------------------------------------
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IROM_AW  = 14
) (
  input logic         clk,
  input logic         rst_n,
  ifu_fetch_if.master fetch_bus
);

  logic [31:0]  r_pc;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_new;
  logic         w_empty;
  logic         w_bypass;
  logic         w_id_valid;
  logic         w_deq;
  logic         w_fetch;
  logic         w_push;
  logic         w_pop;

  // Fetch/handoff control. A redirect kills both the handoff and the fetch.
  always_comb begin
    w_empty = (w_count == 2'd0);
`ifdef FETCH_BYPASS_EN
    w_bypass = w_empty && !fetch_bus.redirect_valid;
`else
    w_bypass = 1'b0;
`endif
    w_id_valid = !fetch_bus.redirect_valid && (!w_empty || w_bypass);
    w_deq      = w_id_valid && fetch_bus.id_ready;
    w_fetch    = !fetch_bus.redirect_valid && ((w_count != 2'd2) || w_deq);
    // A bypassed word taken by decode never enters the queue.
    w_push     = w_fetch && !(w_bypass && fetch_bus.id_ready);
    w_pop      = w_deq && !w_bypass;
    w_new.pc   = r_pc;
    w_new.inst = fetch_bus.irom_data;
  end

  // Program counter: redirect wins, otherwise advance on every fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (fetch_bus.redirect_valid) begin
      r_pc <= align_word(fetch_bus.redirect_pc);
    end else if (w_fetch) begin
      r_pc <= r_pc + 32'd4;
    end else begin
      r_pc <= r_pc;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (fetch_bus.redirect_valid),
    .i_data  (w_new),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Decode-side data: bypass word when forwarding, else the queue head.
  always_comb begin
    if (w_bypass) begin
      fetch_bus.id_inst = w_new.inst;
      fetch_bus.id_pc   = w_new.pc;
    end else begin
      fetch_bus.id_inst = w_head.inst;
      fetch_bus.id_pc   = w_head.pc;
    end
  end

  // Higher PC bits alias onto the IROM word address.
  assign fetch_bus.irom_addr = r_pc[IROM_AW+1:2];
  assign fetch_bus.id_valid  = w_id_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int          AW  = 14;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if #(.IROM_AW(AW)) bus ();

  ifu_fetch #(.RESET_PC(RPC), .IROM_AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus)
  );

  // IROM contents: word k holds 32'hC0DE_0000 + k.
  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return 32'hC0DE_0000 + {18'd0, a};
  endfunction

  assign bus.irom_data = rom(bus.irom_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of {pc, inst} plus the next PC to fetch.
  logic [63:0] mq[$];
  logic [31:0] m_pc = RPC;
  int          cyc = 0;
  int          first_valid_cyc = 0;
  logic [31:0] lg_pc[$];
  logic [31:0] lg_inst[$];
  int          lg_cyc[$];

  function automatic logic [31:0] lpc(input int i);
    if (i < lg_pc.size()) return lg_pc[i];
    return 32'hDEAD_DEAD;
  endfunction
  function automatic logic [31:0] linst(input int i);
    if (i < lg_inst.size()) return lg_inst[i];
    return 32'hDEAD_DEAD;
  endfunction
  function automatic int lcyc(input int i);
    if (i < lg_cyc.size()) return lg_cyc[i];
    return -1000;
  endfunction

  // Per-cycle compare against the model, then advance the model one edge.
  always @(negedge clk) begin
    logic        bypass, ev, deq;
    logic [31:0] ei, ep;
    int          sz;
    if (!rst_n) begin
      mq.delete();
      m_pc = RPC;
      cyc = 0;
      first_valid_cyc = 0;
      check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
      check("rst_id_inst", bus.id_inst, 32'h0000_0013);
      check("rst_id_pc", bus.id_pc, 32'd0);
      check("rst_irom_addr", {18'd0, bus.irom_addr}, {18'd0, RPC[AW+1:2]});
    end else begin
      cyc++;
      sz = mq.size();
`ifdef FETCH_BYPASS_EN
      bypass = (sz == 0) && !bus.redirect_valid;
`else
      bypass = 1'b0;
`endif
      ev = !bus.redirect_valid && (sz > 0 || bypass);
      if (bypass) begin
        ei = rom(m_pc[AW+1:2]);
        ep = m_pc;
      end else if (sz > 0) begin
        ei = mq[0][31:0];
        ep = mq[0][63:32];
      end else begin
        ei = 32'h0000_0013;
        ep = 32'd0;
      end
      check("id_valid", {31'd0, bus.id_valid}, {31'd0, ev});
      if (ev || (sz == 0 && !bypass)) begin
        check("id_inst", bus.id_inst, ei);
        check("id_pc", bus.id_pc, ep);
      end
      check("irom_addr", {18'd0, bus.irom_addr}, {18'd0, m_pc[AW+1:2]});
      if (bus.id_valid && bus.id_ready) begin
        lg_pc.push_back(bus.id_pc);
        lg_inst.push_back(bus.id_inst);
        lg_cyc.push_back(cyc);
      end
      if (bus.id_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
      deq = ev && bus.id_ready;
      if (bus.redirect_valid) begin
        mq.delete();
        m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (deq && !bypass) void'(mq.pop_front());
        if (sz < 2 || deq) begin
          if (!(bypass && bus.id_ready)) mq.push_back({m_pc, rom(m_pc[AW+1:2])});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    lg_pc.delete();
    lg_inst.delete();
    lg_cyc.delete();
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.id_ready = ready;
    step(2);
    rst_n = 1'b1;
    clear_log();
  endtask

  initial begin
    int rd_cyc;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.id_ready = 1'b0;

    // Streaming with decode always ready.
    do_reset(1'b1);
    step(6);
    check("s1_pc0", lpc(0), 32'h0000_0000);
    check("s1_pc1", lpc(1), 32'h0000_0004);
    check("s1_pc2", lpc(2), 32'h0000_0008);
    check("s1_pc3", lpc(3), 32'h0000_000C);
    check("s1_inst0", linst(0), 32'hC0DE_0000);
    check("s1_inst3", linst(3), 32'hC0DE_0003);
    check("s1_no_bubble", lcyc(3) - lcyc(0), 32'd3);
    check("s1_first_valid", first_valid_cyc, LAT);

    // Back-pressure: queue fills, pc stalls, then drains back-to-back.
    do_reset(1'b0);
    step(5);
    check("s2_irom_addr", {18'd0, bus.irom_addr}, 32'd2);
    check("s2_head_valid", {31'd0, bus.id_valid}, 32'd1);
    check("s2_head_pc", bus.id_pc, 32'h0000_0000);
    clear_log();
    bus.id_ready = 1'b1;
    step(4);
    check("s2_pc0", lpc(0), 32'h0000_0000);
    check("s2_pc1", lpc(1), 32'h0000_0004);
    check("s2_pc2", lpc(2), 32'h0000_0008);
    check("s2_b2b", lcyc(2) - lcyc(0), 32'd2);

    // Redirect with a full queue.
    bus.id_ready = 1'b0;
    step(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    rd_cyc = cyc + 1;
    #1;
    check("s3_kill_valid", {31'd0, bus.id_valid}, 32'd0);
    step(1);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.id_ready = 1'b1;
    clear_log();
    step(4);
    check("s3_target_pc", lpc(0), 32'h0000_0100);
    check("s3_target_inst", linst(0), 32'hC0DE_0040);
    check("s3_latency", lcyc(0) - rd_cyc, LAT);

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    step(1);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    clear_log();
    check("s4_addr0", {18'd0, bus.irom_addr}, 32'h0000_3FFE);
    step(1);
    check("s4_addr1", {18'd0, bus.irom_addr}, 32'h0000_3FFF);
    step(1);
    check("s4_addr2", {18'd0, bus.irom_addr}, 32'h0000_0000);
    step(3);
    check("s4_pc0", lpc(0), 32'hFFFF_FFF8);
    check("s4_pc1", lpc(1), 32'hFFFF_FFFC);
    check("s4_pc2", lpc(2), 32'h0000_0000);

    // Asynchronous reset with a full queue.
    bus.id_ready = 1'b0;
    step(3);
    check("s5_pre_valid", {31'd0, bus.id_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", {31'd0, bus.id_valid}, 32'd0);
    check("s5_rst_inst", bus.id_inst, 32'h0000_0013);
    check("s5_rst_pc", bus.id_pc, 32'h0000_0000);
    step(2);
    rst_n = 1'b1;
    clear_log();
    bus.id_ready = 1'b1;
    step(4);
    check("s5_restart_pc", lpc(0), RPC);
    check("s5_restart_inst", linst(0), 32'hC0DE_0000);
    check("s5_first_valid", first_valid_cyc, LAT);

    step(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
